alu_issue_ctrl: RTL and testbench

Issue/control front end that drives the RV32I integer ALU datapath, which consumes IN0, IN1, FUNC3, SUB and ALU_EN and returns OUT. It accepts one OP/OP-IMM instruction plus register operands over a valid/ready handshake, then decodes and validates it. It drives the ALU for exactly one cycle, captures the result, and presents it over a writeback valid/ready handshake. It also flags illegal encodings and counts retired instructions.

---
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/control front end for the RV32I integer ALU: accepts one OP/OP-IMM instruction,
// decodes it, fires the ALU for one cycle and hands the result out over a writeback handshake.
//
// state | meaning
// IDLE  | ready for an instruction; ALU idle
// DEC   | instruction and operands registered, decode/validate in progress
// EXEC  | single ALU cycle, result captured on exit
// WB    | result (or illegal flag) held until the consumer takes it
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INSTR_VALID,
  output logic             INSTR_READY,
  input  logic [31:0]      INSTR,
  input  logic [31:0]      RS1_DATA,
  input  logic [31:0]      RS2_DATA,
  output logic [31:0]      ALU_IN0,
  output logic [31:0]      ALU_IN1,
  output logic [2:0]       ALU_FUNC3,
  output logic             ALU_SUB,
  output logic             ALU_EN,
  input  logic [31:0]      ALU_OUT,
  output logic             WB_VALID,
  input  logic             WB_READY,
  output logic [4:0]       WB_RD,
  output logic [31:0]      WB_DATA,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  state_t state_q, state_d;

  // The rs1 index field is never needed; only the operand value is.
  logic [11:0] instr_hi_q;
  logic [14:0] instr_lo_q;
  logic [31:0] rs1_q, rs2_q;
  logic        unused_rs1_idx;

  logic [31:0]      alu_in0_q, alu_in1_q, wb_data_q;
  logic [2:0]       alu_func3_q;
  logic             alu_sub_q, illegal_q;
  logic [4:0]       wb_rd_q;
  logic [CNT_W-1:0] retired_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        dec_legal, dec_sub;
  logic [31:0] dec_in1;

  assign unused_rs1_idx = ^INSTR[19:15];

  assign opcode = instr_lo_q[6:0];
  assign funct3 = instr_lo_q[14:12];
  assign funct7 = instr_hi_q[11:5];

  always_comb begin
    dec_legal = 1'b0;
    dec_sub   = 1'b0;
    dec_in1   = rs2_q;
    unique case (opcode)
      OPC_OP: begin
        dec_sub   = (funct7 == F7_ALT);
        dec_legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_in1 = {{20{instr_hi_q[11]}}, instr_hi_q};
        unique case (funct3)
          3'b001:  dec_legal = (funct7 == F7_ZERO);
          3'b101: begin
            dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec_sub   = instr_hi_q[10];
          end
          default: dec_legal = 1'b1;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (INSTR_VALID) state_d = DEC;
      DEC:  state_d = dec_legal ? EXEC : WB;
      EXEC: state_d = (wb_rd_q == 5'd0) ? IDLE : WB;
      WB:   if (WB_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      instr_hi_q  <= '0;
      instr_lo_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      alu_func3_q <= '0;
      alu_sub_q   <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (INSTR_VALID) begin
            instr_hi_q <= INSTR[31:20];
            instr_lo_q <= INSTR[14:0];
            rs1_q      <= RS1_DATA;
            rs2_q      <= RS2_DATA;
          end
        end
        DEC: begin
          wb_rd_q   <= instr_lo_q[11:7];
          wb_data_q <= '0;
          illegal_q <= ~dec_legal;
          // ALU operands only change for legal work so they hold between operations.
          if (dec_legal) begin
            alu_in0_q   <= rs1_q;
            alu_in1_q   <= dec_in1;
            alu_func3_q <= funct3;
            alu_sub_q   <= dec_sub;
          end
        end
        EXEC: begin
          wb_data_q <= ALU_OUT;
          retired_q <= retired_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign INSTR_READY = (state_q == IDLE) && !RST;
  assign ALU_EN      = (state_q == EXEC);
  assign WB_VALID    = (state_q == WB);
  assign ALU_IN0     = alu_in0_q;
  assign ALU_IN1     = alu_in1_q;
  assign ALU_FUNC3   = alu_func3_q;
  assign ALU_SUB     = alu_sub_q;
  assign WB_RD       = wb_rd_q;
  assign WB_DATA     = wb_data_q;
  assign ILLEGAL     = illegal_q;
  assign RETIRED_CNT = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU datapath, transaction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_alu_issue_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [31:0]      instr = '0, rs1 = '0, rs2 = '0;
  logic [31:0]      alu_in0, alu_in1, alu_out;
  logic [2:0]       alu_func3;
  logic             alu_sub, alu_en;
  logic             wb_valid, wb_ready = 1'b1;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;

  int n_chk = 0;
  int n_pass = 0;

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
    .INSTR(instr), .RS1_DATA(rs1), .RS2_DATA(rs2),
    .ALU_IN0(alu_in0), .ALU_IN1(alu_in1), .ALU_FUNC3(alu_func3), .ALU_SUB(alu_sub),
    .ALU_EN(alu_en), .ALU_OUT(alu_out), .WB_VALID(wb_valid), .WB_READY(wb_ready),
    .WB_RD(wb_rd), .WB_DATA(wb_data), .ILLEGAL(illegal), .RETIRED_CNT(retired_cnt)
  );

  always #5 clk = ~clk;

  // RV32I integer ALU datapath
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_in0, alu_in1, alu_func3, alu_sub);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one transaction at a time, expectations tied to the accept cycle.
  int          cyc = 0, en_at = 0, wb_from = 0, m_cnt = 0;
  bit          busy = 0, m_legal = 0, m_wb = 0, rst_prev = 0;
  logic [31:0] m_in1, m_in0, m_data;
  logic [2:0]  m_f3;
  logic        m_sub;
  logic [4:0]  m_rd;

  always @(negedge clk) begin
    bit exp_en, exp_wbv;
    cyc++;
    if (rst_prev) begin
      chk("rst_in0", alu_in0, 0);
      chk("rst_in1", alu_in1, 0);
      chk("rst_f3", {29'd0, alu_func3}, 0);
      chk("rst_sub", {31'd0, alu_sub}, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 0);
      chk("rst_illegal", {31'd0, illegal}, 0);
    end
    exp_en  = busy && m_legal && (cyc == en_at);
    exp_wbv = busy && m_wb && (cyc >= wb_from);
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, !busy && !rst});
    chk("alu_en", {31'd0, alu_en}, {31'd0, exp_en});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wbv});
    chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
    if (exp_en) begin
      chk("alu_in0", alu_in0, m_in0);
      chk("alu_in1", alu_in1, m_in1);
      chk("alu_func3", {29'd0, alu_func3}, {29'd0, m_f3});
      chk("alu_sub", {31'd0, alu_sub}, {31'd0, m_sub});
    end
    if (exp_wbv) begin
      chk("wb_data", wb_data, m_data);
      chk("illegal", {31'd0, illegal}, {31'd0, !m_legal});
      if (m_legal) chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
    end
    if (rst) begin
      busy = 0; m_cnt = 0; rst_prev = 1;
    end else begin
      rst_prev = 0;
      if (exp_en) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (!m_wb) busy = 0;
      end else if (exp_wbv && wb_ready) begin
        busy = 0;
      end else if (!busy && instr_valid) begin
        logic [6:0] opc, f7;
        opc = instr[6:0]; f7 = instr[31:25];
        m_f3 = instr[14:12]; m_rd = instr[11:7]; m_in0 = rs1; m_sub = 0;
        if (opc == 7'h33) begin
          m_in1 = rs2; m_sub = (f7 == 7'h20);
          m_legal = (f7 == 0) || (f7 == 7'h20 && (m_f3 == 0 || m_f3 == 5));
        end else if (opc == 7'h13) begin
          m_in1 = {{20{instr[31]}}, instr[31:20]};
          if (m_f3 == 1) m_legal = (f7 == 0);
          else if (m_f3 == 5) begin m_legal = (f7 == 0 || f7 == 7'h20); m_sub = instr[30]; end
          else m_legal = 1;
        end else begin
          m_in1 = rs2; m_legal = 0;
        end
        busy = 1;
        en_at = cyc + 2;
        wb_from = m_legal ? cyc + 3 : cyc + 2;
        m_wb = !m_legal || (m_rd != 0);
        m_data = m_legal ? alu_fn(m_in0, m_in1, m_f3, m_sub) : 32'd0;
      end
    end
  end

  // Directed transaction with literal expectations; inputs change 2ns after a rising edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit exp_ill, input logic [31:0] exp_in1,
                       input logic [31:0] exp_data, input logic [4:0] exp_rd);
    int t = 0;
    while (!instr_ready && t < 20) begin @(posedge clk); #2; t++; end
    chk("ready_before_issue", {31'd0, instr_ready}, 1);
    instr_valid = 1; instr = ins; rs1 = a; rs2 = b; wb_ready = (hold == 0);
    @(posedge clk); #2;
    instr_valid = 0; instr = 32'hDEAD_BEEF; rs1 = '1; rs2 = '1;
    if (!exp_ill) begin
      @(posedge clk); #2;
      chk("lit_alu_en", {31'd0, alu_en}, 1);
      chk("lit_alu_in1", alu_in1, exp_in1);
    end
    if (exp_ill || exp_rd != 0) begin
      t = 0;
      while (!wb_valid && t < 10) begin @(posedge clk); #2; t++; end
      chk("lit_wb_latency", t, 1);
      chk("lit_wb_data", wb_data, exp_data);
      chk("lit_illegal", {31'd0, illegal}, {31'd0, exp_ill});
      if (!exp_ill) chk("lit_wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
      repeat (hold) begin @(posedge clk); #2; end
      if (hold > 0) chk("lit_wb_held", {31'd0, wb_valid}, 1);
      wb_ready = 1;
    end else begin
      @(posedge clk); #2;
      chk("lit_x0_ready", {31'd0, instr_ready}, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_ready", {31'd0, instr_ready}, 0);
    chk("lit_rst_cnt", 32'(retired_cnt), 0);
    rst = 0;
    issue(32'h002081B3, 5, 7, 0, 0, 32'd7, 32'd12, 5'd3);
    issue(32'h402081B3, 5, 7, 0, 0, 32'd7, 32'hFFFF_FFFE, 5'd3);
    issue(32'hFFF00093, 0, 9, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    issue(32'h40435293, 32'h8000_0000, 3, 0, 0, 32'h0000_0404, 32'hF800_0000, 5'd5);
    issue(32'h0FF14093, 32'h0000_F0F0, 0, 0, 0, 32'h0000_00FF, 32'h0000_F00F, 5'd1);
    issue(32'h020081B3, 5, 7, 0, 1, 0, 0, 0);
    issue(32'h0000006F, 5, 7, 0, 1, 0, 0, 0);
    issue(32'h402091B3, 5, 7, 0, 1, 0, 0, 0);
    issue(32'h02009093, 5, 7, 0, 1, 0, 0, 0);
    issue(32'h002081B3, 32'd100, 32'd23, 5, 0, 32'd23, 32'd123, 5'd3);
    issue(32'h00208033, 1, 2, 0, 0, 32'd2, 0, 5'd0);
    // reset while the ALU is executing, with a handshake offered during reset
    while (!instr_ready) begin @(posedge clk); #2; end
    instr_valid = 1; instr = 32'h002081B3; rs1 = 1; rs2 = 1;
    @(posedge clk); #2; instr_valid = 0;
    @(posedge clk); #2;
    chk("lit_exec_before_rst", {31'd0, alu_en}, 1);
    rst = 1; instr_valid = 1;
    @(posedge clk); #2;
    chk("lit_mid_rst_cnt", 32'(retired_cnt), 0);
    chk("lit_mid_rst_ready", {31'd0, instr_ready}, 0);
    chk("lit_mid_rst_en", {31'd0, alu_en}, 0);
    @(posedge clk); #2;
    rst = 0; instr_valid = 0;
    issue(32'h002081B3, 2, 3, 0, 0, 32'd3, 32'd5, 5'd3);
    chk("lit_cnt_after_rst", 32'(retired_cnt), 1);
    for (int i = 0; i < 4; i++)
      issue(32'h002081B3, i, 10, 0, 0, 32'd10, 32'(i + 10), 5'd3);
    chk("lit_cnt_wrap", 32'(retired_cnt), 1);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
